cdrive_sync_rx: RTL

- Clocked receive stage that sits directly downstream of one output branch of the 7-way cSplitter.
- Accepts one drive/free token from the asynchronous click domain and synchronizes the drive event into the clk domain.
- Buffers the data word in a small first-word-fall-through (FWFT) FIFO and presents it on a valid/ready interface.
- Returns a free pulse to the splitter's i_freeNext_7[n] input once a FIFO slot is guaranteed for the next token.

---
 rtl/cdrive_sync_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cdrive_sync_rx.sv
// Clocked receive stage for one cSplitter branch: synchronizes the async drive event, buffers the word in an FWFT FIFO, returns a free pulse.
// Optional overflow detection is enabled with `define CDRIVE_SYNC_RX_OVF_EN.
module cdrive_sync_rx #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int FREE_PULSE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_drive,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_free,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FREE_PULSE_CYCLES + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'((FREE_PULSE_CYCLES > 1) ? FREE_PULSE_CYCLES - 2 : 0);

  typedef enum logic [1:0] {IDLE, PEND, PULSE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   ev;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [LW-1:0]          level, lvl_nxt;
  logic                   full, push, pop;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_drive};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev   = sync_q[SYNC_STAGES-1] & ~hist;
  assign full = (level == FULL_LVL);
  assign pop  = o_valid & i_ready;
  // A push into a full FIFO is only allowed when the head leaves in the same cycle.
  assign push = ev & (~full | pop);

  always_comb begin
    lvl_nxt = level;
    case ({push, pop})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= lvl_nxt;
    end
  end

  assign o_level = level;
  assign o_valid = (level != '0);
  assign o_data  = o_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (ev) state_nxt = PEND;
      PEND: begin
        // The PEND cycle that releases the slot is already the first o_free cycle.
        if (lvl_nxt < FULL_LVL) begin
          state_nxt = (FREE_PULSE_CYCLES > 1) ? PULSE : IDLE;
          cnt_nxt   = '0;
        end
      end
      PULSE: begin
        if (cnt == LAST) state_nxt = IDLE;
        else             cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_free = 1'b0;
    case (state)
      PEND:    o_free = (lvl_nxt < FULL_LVL);
      PULSE:   o_free = 1'b1;
      default: o_free = 1'b0;
    endcase
  end

`ifdef CDRIVE_SYNC_RX_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          ovf_q <= 1'b0;
    else if (ev && ((state != IDLE) || (full && !pop))) ovf_q <= 1'b1;
  end
  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif
endmodule
